// File: rtl/bf_serial_loader.sv
// -----------------------------------------------------------------------------
// bf_serial_loader
//
// Upstream stage of the Brainfuck CPU. It requests bytes one at a time from the
// UART receiver and keeps only the eight Brainfuck opcodes (+ - < > [ ] . ,).
// Opcodes are packed into program memory from address 0. When END_BYTE arrives,
// or the window fills, the rest of the window is padded with 8'h00. Bracket
// balance is tracked on the fly, so the core knows about an unbalanced program
// before its jump-table preprocessing starts.
//
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset
//   load_req    level request to (re)load; it must fall and rise again to reload
//   rx_start    one-cycle pulse that arms the receiver for the next byte
//   rx_busy     receiver busy; rx_data is valid when it falls
//   rx_data     received byte
//   prog_we     program memory write strobe
//   prog_addr   program memory write address (held while prog_we is low)
//   prog_wr     program memory write data (held while prog_we is low)
//   loaded      program stored and padded
//   load_error  bracket imbalance (underflow or unclosed '['); valid while loaded
//   prog_count  number of opcodes stored
// -----------------------------------------------------------------------------
module bf_serial_loader #(
  parameter int unsigned PROG_ADDR_WIDTH = 14,
  parameter int unsigned PROG_LEN        = 16383,
  parameter logic [7:0]  END_BYTE        = 8'h21
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       load_req,
  output logic                       rx_start,
  input  logic                       rx_busy,
  input  logic [7:0]                 rx_data,
  output logic                       prog_we,
  output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  output logic [7:0]                 prog_wr,
  output logic                       loaded,
  output logic                       load_error,
  output logic [PROG_ADDR_WIDTH-1:0] prog_count
);

  // The write pointer has to reach PROG_LEN itself, so it gets one extra bit.
  // That keeps it safe even if PROG_LEN is set to 2**PROG_ADDR_WIDTH.
  localparam int unsigned        PW  = PROG_ADDR_WIDTH + 1;
  localparam logic [PW-1:0]      LEN = PW'(PROG_LEN);
  localparam logic [PW-1:0]      ONE = PW'(1);
  localparam logic [PROG_ADDR_WIDTH-1:0] CNT_ONE = PROG_ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_START,
    S_RX_ARM,
    S_RX_WAIT,
    S_FILTER,
    S_PAD,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              depth_q, depth_d;
  logic                       underflow_q, underflow_d;
  logic [7:0]                 byte_q, byte_d;
  logic                       rx_start_q, rx_start_d;
  logic                       prog_we_q, prog_we_d;
  logic [PROG_ADDR_WIDTH-1:0] prog_addr_q, prog_addr_d;
  logic [7:0]                 prog_wr_q, prog_wr_d;
  logic                       loaded_q, loaded_d;
  logic                       load_error_q, load_error_d;
  logic [PROG_ADDR_WIDTH-1:0] prog_count_q, prog_count_d;

  logic                       is_opcode;
  logic [PW-1:0]              wr_ptr_inc;

  always_comb begin
    case (byte_q)
      8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: is_opcode = 1'b1;
      default:                                                is_opcode = 1'b0;
    endcase
  end

  assign wr_ptr_inc = wr_ptr_q + ONE;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    depth_d      = depth_q;
    underflow_d  = underflow_q;
    byte_d       = byte_q;
    rx_start_d   = 1'b0;
    prog_we_d    = 1'b0;
    prog_addr_d  = prog_addr_q;
    prog_wr_d    = prog_wr_q;
    loaded_d     = loaded_q;
    load_error_d = load_error_q;
    prog_count_d = prog_count_q;

    // rx_start_d is raised on every transition into S_RX_START. The registered
    // pulse is then high for exactly the S_RX_START cycle.
    case (state_q)
      S_IDLE: begin
        if (load_req) begin
          wr_ptr_d     = '0;
          depth_d      = '0;
          underflow_d  = 1'b0;
          prog_count_d = '0;
          loaded_d     = 1'b0;
          load_error_d = 1'b0;
          rx_start_d   = 1'b1;
          state_d      = S_RX_START;
        end
      end

      S_RX_START: state_d = S_RX_ARM;

      // Dead cycle: the receiver raises rx_busy only after it sees rx_start.
      S_RX_ARM:   state_d = S_RX_WAIT;

      S_RX_WAIT: begin
        if (!rx_busy) begin
          byte_d  = rx_data;
          state_d = S_FILTER;
        end
      end

      S_FILTER: begin
        if (byte_q == END_BYTE) begin
          state_d = S_PAD;
        end else if (is_opcode) begin
          prog_we_d    = 1'b1;
          prog_addr_d  = wr_ptr_q[PROG_ADDR_WIDTH-1:0];
          prog_wr_d    = byte_q;
          wr_ptr_d     = wr_ptr_inc;
          prog_count_d = prog_count_q + CNT_ONE;
          if (byte_q == 8'h5B) begin
            if (depth_q != '1) begin
              depth_d = depth_q + ONE;
            end
          end else if (byte_q == 8'h5D) begin
            if (depth_q == '0) begin
              underflow_d = 1'b1;
            end else begin
              depth_d = depth_q - ONE;
            end
          end
          // A full window stops fetching. The next byte stays in the receiver.
          if (wr_ptr_inc == LEN) begin
            state_d = S_PAD;
          end else begin
            rx_start_d = 1'b1;
            state_d    = S_RX_START;
          end
        end else begin
          rx_start_d = 1'b1;
          state_d    = S_RX_START;
        end
      end

      S_PAD: begin
        if (wr_ptr_q < LEN) begin
          prog_we_d   = 1'b1;
          prog_addr_d = wr_ptr_q[PROG_ADDR_WIDTH-1:0];
          prog_wr_d   = 8'h00;
          wr_ptr_d    = wr_ptr_inc;
        end else begin
          // The final write strobe is visible this cycle. loaded follows one
          // cycle later.
          loaded_d     = 1'b1;
          load_error_d = underflow_q | (depth_q != '0);
          state_d      = S_DONE;
        end
      end

      S_DONE: begin
        if (!load_req) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      depth_q      <= '0;
      underflow_q  <= 1'b0;
      byte_q       <= '0;
      rx_start_q   <= 1'b0;
      prog_we_q    <= 1'b0;
      prog_addr_q  <= '0;
      prog_wr_q    <= '0;
      loaded_q     <= 1'b0;
      load_error_q <= 1'b0;
      prog_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      depth_q      <= depth_d;
      underflow_q  <= underflow_d;
      byte_q       <= byte_d;
      rx_start_q   <= rx_start_d;
      prog_we_q    <= prog_we_d;
      prog_addr_q  <= prog_addr_d;
      prog_wr_q    <= prog_wr_d;
      loaded_q     <= loaded_d;
      load_error_q <= load_error_d;
      prog_count_q <= prog_count_d;
    end
  end

  assign rx_start   = rx_start_q;
  assign prog_we    = prog_we_q;
  assign prog_addr  = prog_addr_q;
  assign prog_wr    = prog_wr_q;
  assign loaded     = loaded_q;
  assign load_error = load_error_q;
  assign prog_count = prog_count_q;

endmodule

// File: tb/tb_bf_serial_loader.sv
// -----------------------------------------------------------------------------
// tb_bf_serial_loader
//
// Bench for bf_serial_loader with an 8-byte program window. A receiver model
// hands out bytes from a stream queue and stays busy for 17 cycles per byte. A
// monitor logs every program-memory write and when loaded rises. A reference
// model computes the expected writes, count, error flag and number of rx_start
// pulses directly from the loader rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bf_serial_loader;

  localparam int         AW   = 4;
  localparam int         PLEN = 8;
  localparam logic [7:0] ENDB = 8'h21;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          load_req = 1'b0;
  logic          rx_start;
  logic          rx_busy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_wr;
  logic          loaded;
  logic          load_error;
  logic [AW-1:0] prog_count;

  bf_serial_loader #(
    .PROG_ADDR_WIDTH(AW),
    .PROG_LEN(PLEN),
    .END_BYTE(ENDB)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .load_req(load_req),
    .rx_start(rx_start),
    .rx_busy(rx_busy),
    .rx_data(rx_data),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_wr(prog_wr),
    .loaded(loaded),
    .load_error(load_error),
    .prog_count(prog_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Receiver model and monitor state.
  byte unsigned rx_q[$];
  int           start_cnt = 0;
  int           start_base = 0;
  int           busy_cnt = 0;
  int           cyc = 0;
  int           w_addr[$];
  int           w_data[$];
  int           w_cyc[$];
  int           rise_cyc = -1;
  logic         prev_loaded = 1'b0;

  // Reference model results.
  int exp_addr[$];
  int exp_data[$];
  int exp_count;
  int exp_err;
  int exp_starts;

  typedef struct {
    string name;
    string s;
    int    count;
    int    err;
    int    starts;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit is_op(input byte unsigned b);
    return b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C};
  endfunction

  // Walk the stream the way the loader consumes it. Every consumed byte costs
  // one rx_start pulse.
  task automatic build_model(input byte unsigned s[$]);
    int ptr;
    int depth;
    bit uf;
    int used;
    bit stop;
    ptr = 0; depth = 0; uf = 1'b0; used = 0; stop = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < s.size() && !stop; i++) begin
      if (ptr == PLEN) begin
        stop = 1'b1;
      end else begin
        used++;
        if (s[i] == ENDB) begin
          stop = 1'b1;
        end else if (is_op(s[i])) begin
          exp_addr.push_back(ptr);
          exp_data.push_back(int'(s[i]));
          ptr++;
          if (s[i] == 8'h5B) depth++;
          else if (s[i] == 8'h5D) begin
            if (depth == 0) uf = 1'b1;
            else depth--;
          end
        end
      end
    end
    exp_count  = ptr;
    exp_err    = (uf || depth != 0) ? 1 : 0;
    exp_starts = used;
    while (ptr < PLEN) begin
      exp_addr.push_back(ptr);
      exp_data.push_back(0);
      ptr++;
    end
  endtask

  task automatic rx_loop();
    forever begin
      @(negedge clk);
      if (!resetn) begin
        busy_cnt = 0;
        rx_busy  = 1'b0;
      end else begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) rx_busy = 1'b0;
        end
        if (rx_start === 1'b1) begin
          start_cnt++;
          busy_cnt = 17;
          rx_busy  = 1'b1;
          if (rx_q.size() > 0) rx_data = rx_q.pop_front();
          else rx_data = ENDB;
        end
      end
    end
  endtask

  task automatic mon_loop();
    forever begin
      @(negedge clk);
      cyc++;
      if (prog_we === 1'b1) begin
        w_addr.push_back(int'(prog_addr));
        w_data.push_back(int'(prog_wr));
        w_cyc.push_back(cyc);
      end
      if (loaded === 1'b1 && prev_loaded == 1'b0 && rise_cyc < 0) rise_cyc = cyc;
      prev_loaded = loaded;
    end
  endtask

  task automatic prep(input byte unsigned s[$]);
    rx_q = s;
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
    rise_cyc   = -1;
    start_base = start_cnt;
    build_model(s);
  endtask

  task automatic wait_loaded(input string tag);
    int n;
    n = 0;
    while (rise_cyc < 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (rise_cyc < 0) check({tag, " loaded timeout"}, 0, 1);
  endtask

  task automatic verify(input string tag);
    int a;
    int d;
    int gaps;
    check({tag, " nwrites"}, w_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      a = (i < w_addr.size()) ? w_addr[i] : -1;
      d = (i < w_data.size()) ? w_data[i] : -1;
      check($sformatf("%s write%0d addr/data", tag, i), (a << 8) | (d & 8'hFF),
            (exp_addr[i] << 8) | exp_data[i]);
    end
    check({tag, " prog_count"}, int'(prog_count), exp_count);
    check({tag, " load_error"}, int'(load_error), exp_err);
    check({tag, " loaded"}, int'(loaded), 1);
    check({tag, " rx_starts"}, start_cnt - start_base, exp_starts);
    if (w_cyc.size() > 0)
      check({tag, " loaded timing"}, rise_cyc, w_cyc[w_cyc.size()-1] + 1);
    gaps = 0;
    for (int i = exp_count + 1; i < w_cyc.size(); i++)
      if (w_cyc[i] != w_cyc[i-1] + 1) gaps++;
    check({tag, " pad gaps"}, gaps, 0);
    $display("load %-12s count=%0d err=%0d starts=%0d writes=%0d", tag,
             int'(prog_count), int'(load_error), start_cnt - start_base, w_addr.size());
  endtask

  task automatic run_load(input string tag, input byte unsigned s[$]);
    prep(s);
    @(negedge clk);
    load_req = 1'b0;
    repeat (2) @(negedge clk);
    load_req = 1'b1;
    wait_loaded(tag);
    verify(tag);
  endtask

  initial begin
    byte unsigned q[$];
    byte unsigned pool[12];
    int found;
    int base;

    tbl[0] = '{"basic",   "+a[-]\n!",   4, 0, 7};
    tbl[1] = '{"underfl", "][!",        2, 1, 3};
    tbl[2] = '{"unclosed", "[[]!",      3, 1, 4};
    tbl[3] = '{"full",    "++++++++++", 8, 0, 8};
    tbl[4] = '{"empty",   "!",          0, 0, 1};
    pool = '{8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C,
             8'h61, 8'h0A, 8'h0D, 8'h20};

    fork
      rx_loop();
      mon_loop();
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset rx_start",   int'(rx_start), 0);
    check("reset prog_we",    int'(prog_we), 0);
    check("reset prog_addr",  int'(prog_addr), 0);
    check("reset prog_wr",    int'(prog_wr), 0);
    check("reset loaded",     int'(loaded), 0);
    check("reset load_error", int'(load_error), 0);
    check("reset prog_count", int'(prog_count), 0);
    @(negedge clk);
    #2 resetn = 1'b1;

    // Table-driven streams.
    for (int t = 0; t < 5; t++) begin
      q.delete();
      for (int i = 0; i < tbl[t].s.len(); i++) q.push_back(byte'(tbl[t].s[i]));
      run_load(tbl[t].name, q);
      check({tbl[t].name, " tbl count"},  int'(prog_count), tbl[t].count);
      check({tbl[t].name, " tbl err"},    int'(load_error), tbl[t].err);
      check({tbl[t].name, " tbl starts"}, start_cnt - start_base, tbl[t].starts);
    end

    // Randomized streams against the reference model.
    for (int r = 0; r < 10; r++) begin
      int len;
      q.delete();
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 14) == 0) q.push_back(ENDB);
        else q.push_back(pool[$urandom_range(0, 11)]);
      end
      q.push_back(ENDB);
      run_load($sformatf("rand%0d", r), q);
    end

    // Asynchronous reset in the middle of a receive.
    q.delete();
    q = '{8'h2B, 8'h2B, 8'h2B, ENDB};
    prep(q);
    @(negedge clk);
    load_req = 1'b0;
    repeat (2) @(negedge clk);
    load_req = 1'b1;
    repeat (40) @(negedge clk);
    #3 resetn = 1'b0;
    #1;
    check("midreset rx_start",   int'(rx_start), 0);
    check("midreset prog_we",    int'(prog_we), 0);
    check("midreset loaded",     int'(loaded), 0);
    check("midreset load_error", int'(load_error), 0);
    check("midreset prog_count", int'(prog_count), 0);
    repeat (2) @(negedge clk);
    q.delete();
    q = '{8'h2E, 8'h2C, 8'h2B, ENDB};
    prep(q);
    @(negedge clk);
    #2 resetn = 1'b1;
    found = 0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      if (rx_start === 1'b1 && found == 0) found = k;
    end
    check("postreset rx_start within 2", (found >= 1) ? 1 : 0, 1);
    wait_loaded("postreset");
    verify("postreset");

    // A held load_req must not start another load. A one-cycle drop reloads.
    base = start_cnt;
    repeat (30) @(negedge clk);
    check("hold no rx_start", start_cnt - base, 0);
    check("hold loaded", int'(loaded), 1);
    q.delete();
    q = '{8'h2E, 8'h2C, ENDB};
    prep(q);
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    check("reload loaded cleared", int'(loaded), 0);
    check("reload rx_start", int'(rx_start), 1);
    wait_loaded("reload");
    verify("reload");
    check("reload count", int'(prog_count), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
